// File: rtl/fpnew_req_sched.sv
// fpnew_req_sched: shares one FPU between NumReq issue ports with round-robin issue,
// per-requester credits, a 1-entry response register, flush and drain/quiesce.
// Optional perf counters are built when FPNEW_REQ_SCHED_PERF_EN is defined.
module fpnew_req_sched #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned OpWidth        = 256,
  parameter int unsigned RspWidth       = 69,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdWidth       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumReq-1:0]                 req_valid_i,
  output logic [NumReq-1:0]                 req_ready_o,
  input  logic [NumReq-1:0][OpWidth-1:0]    req_data_i,
  output logic                              fpu_valid_o,
  input  logic                              fpu_ready_i,
  output logic [OpWidth-1:0]                fpu_data_o,
  output logic [IdWidth-1:0]                fpu_tag_o,
  output logic                              fpu_flush_o,
  input  logic                              fpu_rsp_valid_i,
  output logic                              fpu_rsp_ready_o,
  input  logic [RspWidth-1:0]               fpu_rsp_data_i,
  input  logic [IdWidth-1:0]                fpu_rsp_tag_i,
  output logic [NumReq-1:0]                 rsp_valid_o,
  input  logic [NumReq-1:0]                 rsp_ready_i,
  output logic [RspWidth-1:0]               rsp_data_o,
  input  logic                              flush_i,
  input  logic                              drain_req_i,
  output logic                              drain_done_o,
  output logic                              busy_o
`ifdef FPNEW_REQ_SCHED_PERF_EN
  ,
  output logic [NumReq-1:0][31:0]           perf_issue_o,
  output logic [31:0]                       perf_stall_o
`endif
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  typedef enum logic [1:0] {
    RUN,
    HOLD,
    DRAIN,
    DRAINED
  } state_e;

  state_e                            state_q;
  logic [IdWidth-1:0]                ptr_q;
  logic [IdWidth-1:0]                hold_idx_q;
  logic [IdWidth-1:0]                rr_idx;
  logic [IdWidth-1:0]                grant_idx;
  logic                              any_elig;
  logic                              hs;
  logic [NumReq-1:0]                 elig;
  logic [NumReq-1:0]                 inc;
  logic [NumReq-1:0]                 dec;
  logic [NumReq-1:0]                 tag_hit;
  logic [NumReq-1:0][CntWidth-1:0]   cnt_q;
  logic [NumReq-1:0][CntWidth-1:0]   cnt_d;

  logic                              rsp_full_q;
  logic                              rsp_full_d;
  logic [IdWidth-1:0]                rsp_tag_q;
  logic [RspWidth-1:0]               rsp_data_q;
  logic                              rsp_drain;
  logic                              rsp_beat;
  logic                              rsp_load;
  logic                              quiet;

  // Eligibility, per-requester grant strobe and credit update
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
    assign elig[gi]        = req_valid_i[gi] && (cnt_q[gi] < CntWidth'(MaxOutstanding));
    assign req_ready_o[gi] = hs && (grant_idx == IdWidth'(gi));
    assign inc[gi]         = req_ready_o[gi];
    assign tag_hit[gi]     = (fpu_rsp_tag_i == IdWidth'(gi)) && (cnt_q[gi] != '0);
    assign dec[gi]         = rsp_beat && tag_hit[gi];
    assign rsp_valid_o[gi] = rsp_full_q && (rsp_tag_q == IdWidth'(gi));
    assign cnt_d[gi]       = flush_i ? '0
                           : cnt_q[gi] + CntWidth'(inc[gi]) - CntWidth'(dec[gi]);
  end

  // Scan from the highest offset down so the first eligible index after ptr wins
  always_comb begin
    int idx;
    rr_idx   = '0;
    any_elig = 1'b0;
    idx      = 0;
    for (int off = int'(NumReq) - 1; off >= 0; off--) begin
      idx = (int'(ptr_q) + off) % int'(NumReq);
      if (elig[idx]) begin
        rr_idx   = IdWidth'(idx);
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    fpu_valid_o = 1'b0;
    if (!flush_i) begin
      case (state_q)
        RUN:     fpu_valid_o = any_elig;
        HOLD:    fpu_valid_o = 1'b1;
        default: fpu_valid_o = 1'b0;
      endcase
    end
  end

  assign grant_idx   = (state_q == HOLD) ? hold_idx_q : rr_idx;
  assign fpu_tag_o   = grant_idx;
  assign fpu_data_o  = req_data_i[grant_idx];
  assign hs          = fpu_valid_o && fpu_ready_i;
  assign fpu_flush_o = flush_i;

  // Response register: a beat is accepted while flushing but never loaded
  assign rsp_drain       = rsp_full_q && rsp_ready_i[rsp_tag_q];
  assign fpu_rsp_ready_o = flush_i || !rsp_full_q || rsp_drain;
  assign rsp_beat        = fpu_rsp_valid_i && fpu_rsp_ready_o && !flush_i;
  assign rsp_load        = |dec;
  assign rsp_data_o      = rsp_data_q;

  always_comb begin
    rsp_full_d = rsp_full_q;
    if (flush_i) begin
      rsp_full_d = 1'b0;
    end else if (rsp_load) begin
      rsp_full_d = 1'b1;
    end else if (rsp_drain) begin
      rsp_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_full_q <= 1'b0;
      rsp_tag_q  <= '0;
      rsp_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      rsp_full_q <= rsp_full_d;
      cnt_q      <= cnt_d;
      if (rsp_load) begin
        rsp_tag_q  <= fpu_rsp_tag_i;
        rsp_data_q <= fpu_rsp_data_i;
      end
    end
  end

  // Quiescence looks at next-state values so drain_done follows the last consume by one cycle
  assign quiet = (cnt_d == '0) && !rsp_full_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      ptr_q      <= '0;
      hold_idx_q <= '0;
    end else begin
      if (hs) begin
        ptr_q <= (grant_idx == IdWidth'(NumReq - 1)) ? '0 : grant_idx + IdWidth'(1);
      end
      if (flush_i) begin
        case (state_q)
          HOLD:           state_q <= RUN;
          DRAIN, DRAINED: if (!drain_req_i) state_q <= RUN;
          default:        if (drain_req_i) state_q <= DRAIN;
        endcase
      end else begin
        case (state_q)
          RUN: begin
            if (fpu_valid_o && !fpu_ready_i) begin
              state_q    <= HOLD;
              hold_idx_q <= rr_idx;
            end else if (drain_req_i) begin
              state_q <= DRAIN;
            end
          end
          HOLD: begin
            if (fpu_ready_i) state_q <= drain_req_i ? DRAIN : RUN;
          end
          DRAIN: begin
            if (!drain_req_i) state_q <= RUN;
            else if (quiet) state_q <= DRAINED;
          end
          default: begin
            if (!drain_req_i) state_q <= RUN;
          end
        endcase
      end
    end
  end

  assign drain_done_o = (state_q == DRAINED);
  assign busy_o       = (|cnt_q) || rsp_full_q || (state_q == HOLD);

  // A result carrying a tag with no op in flight is dropped; flag it in simulation
  rsp_tag_live_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (fpu_rsp_valid_i && fpu_rsp_ready_o && !flush_i) |-> (|tag_hit));

`ifdef FPNEW_REQ_SCHED_PERF_EN
  logic [NumReq-1:0][31:0] perf_issue_q;
  logic [31:0]             perf_stall_q;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_perf
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        perf_issue_q[gi] <= '0;
      end else if (inc[gi] && (perf_issue_q[gi] != '1)) begin
        perf_issue_q[gi] <= perf_issue_q[gi] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_q <= '0;
    end else if ((|req_valid_i) && !hs && (perf_stall_q != '1)) begin
      perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issue_o = perf_issue_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_fpnew_req_sched.sv
// Directed self-checking bench for fpnew_req_sched (NumReq=2, MaxOutstanding=4).
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_fpnew_req_sched;

  localparam int NumReq   = 2;
  localparam int OpWidth  = 256;
  localparam int RspWidth = 69;

  logic                           clk = 1'b0;
  logic                           rst_i;
  logic [NumReq-1:0]              req_valid_i;
  logic [NumReq-1:0]              req_ready_o;
  logic [NumReq-1:0][OpWidth-1:0] req_data_i;
  logic                           fpu_valid_o;
  logic                           fpu_ready_i;
  logic [OpWidth-1:0]             fpu_data_o;
  logic [0:0]                     fpu_tag_o;
  logic                           fpu_flush_o;
  logic                           fpu_rsp_valid_i;
  logic                           fpu_rsp_ready_o;
  logic [RspWidth-1:0]            fpu_rsp_data_i;
  logic [0:0]                     fpu_rsp_tag_i;
  logic [NumReq-1:0]              rsp_valid_o;
  logic [NumReq-1:0]              rsp_ready_i;
  logic [RspWidth-1:0]            rsp_data_o;
  logic                           flush_i;
  logic                           drain_req_i;
  logic                           drain_done_o;
  logic                           busy_o;
`ifdef FPNEW_REQ_SCHED_PERF_EN
  logic [NumReq-1:0][31:0]        perf_issue_o;
  logic [31:0]                    perf_stall_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpnew_req_sched #(
    .NumReq(NumReq), .OpWidth(OpWidth), .RspWidth(RspWidth), .MaxOutstanding(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
    .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i), .fpu_data_o(fpu_data_o),
    .fpu_tag_o(fpu_tag_o), .fpu_flush_o(fpu_flush_o),
    .fpu_rsp_valid_i(fpu_rsp_valid_i), .fpu_rsp_ready_o(fpu_rsp_ready_o),
    .fpu_rsp_data_i(fpu_rsp_data_i), .fpu_rsp_tag_i(fpu_rsp_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .flush_i(flush_i), .drain_req_i(drain_req_i), .drain_done_o(drain_done_o),
    .busy_o(busy_o)
`ifdef FPNEW_REQ_SCHED_PERF_EN
    , .perf_issue_o(perf_issue_o), .perf_stall_o(perf_stall_o)
`endif
  );

  task automatic clear_inputs();
    req_valid_i     = '0;
    req_data_i      = '0;
    fpu_ready_i     = 1'b0;
    fpu_rsp_valid_i = 1'b0;
    fpu_rsp_data_i  = '0;
    fpu_rsp_tag_i   = '0;
    rsp_ready_i     = 2'b11;
    flush_i         = 1'b0;
    drain_req_i     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    fpu_ready_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      req_valid_i = 2'b01;
    end
    do_reset();
    @(negedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++;
    if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid_o); end
    checks++;
    if (fpu_valid_o !== 1'b0 || req_ready_o !== 2'b00) begin
      errors++; $display("FAIL reset_issue got valid=%b ready=%b exp 0/00", fpu_valid_o, req_ready_o);
    end
    checks++;
    if (drain_done_o !== 1'b0) begin errors++; $display("FAIL reset_drain_done got %b exp 0", drain_done_o); end
    $display("reset: busy=%b rsp_valid=%b", busy_o, rsp_valid_o);
  endtask

  task automatic test_rr_fairness();
    logic [1:0] exp_rdy [5];
    logic       exp_tag [5];
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    exp_tag = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    req_data_i[0] = 256'hA0;
    req_data_i[1] = 256'hB1;
    fpu_ready_i   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid_i = 2'b11;
      #1;
      checks++;
      if (fpu_tag_o !== exp_tag[k] || req_ready_o !== exp_rdy[k]) begin
        errors++;
        $display("FAIL rr_grant[%0d] got tag=%0d ready=%b exp tag=%0d ready=%b",
                 k, fpu_tag_o, req_ready_o, exp_tag[k], exp_rdy[k]);
      end
      checks++;
      if (fpu_data_o !== (exp_tag[k] ? 256'hB1 : 256'hA0)) begin
        errors++; $display("FAIL rr_data[%0d] got %0h", k, fpu_data_o);
      end
      $display("rr: grant %0d tag=%0d ready=%b", k, fpu_tag_o, req_ready_o);
    end
    @(negedge clk);
    req_valid_i = 2'b00;
  endtask

  task automatic test_credit_limit();
    do_reset();
    req_data_i[0] = 256'hC0;
    fpu_ready_i   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req_valid_i = 2'b01;
      #1;
      checks++;
      if (req_ready_o !== ((k < 4) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL credit_issue[%0d] got ready=%b exp %b", k, req_ready_o, (k < 4) ? 2'b01 : 2'b00);
      end
      $display("credit: cycle %0d ready=%b", k, req_ready_o);
    end
    @(negedge clk);
    fpu_rsp_valid_i = 1'b1;
    fpu_rsp_tag_i   = 1'b0;
    fpu_rsp_data_i  = 69'h1_2345;
    #1;
    checks++;
    if (req_ready_o !== 2'b00 || fpu_rsp_ready_o !== 1'b1) begin
      errors++; $display("FAIL credit_rsp_cycle got ready=%b rsp_ready=%b exp 00/1", req_ready_o, fpu_rsp_ready_o);
    end
    @(negedge clk);
    fpu_rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 2'b01) begin errors++; $display("FAIL credit_fifth_issue got %b exp 01", req_ready_o); end
    checks++;
    if (rsp_valid_o !== 2'b01 || rsp_data_o !== 69'h1_2345) begin
      errors++; $display("FAIL credit_rsp_out got valid=%b data=%0h exp 01/12345", rsp_valid_o, rsp_data_o);
    end
    $display("credit: fifth issue ready=%b rsp_valid=%b", req_ready_o, rsp_valid_o);
    @(negedge clk);
    #1;
    checks++;
    if (req_ready_o !== 2'b00 || rsp_valid_o !== 2'b00) begin
      errors++; $display("FAIL credit_refull got ready=%b rsp_valid=%b exp 00/00", req_ready_o, rsp_valid_o);
    end
    req_valid_i = 2'b00;
  endtask

  task automatic test_hold();
    do_reset();
    req_data_i[0] = 256'hD00D;
    req_data_i[1] = 256'hE11E;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid_i = (k == 0) ? 2'b01 : 2'b11;
      fpu_ready_i = 1'b0;
      #1;
      checks++;
      if (fpu_valid_o !== 1'b1 || fpu_tag_o !== 1'b0 || fpu_data_o !== 256'hD00D || req_ready_o !== 2'b00) begin
        errors++;
        $display("FAIL hold_stable[%0d] got valid=%b tag=%0d data=%0h ready=%b exp 1/0/d00d/00",
                 k, fpu_valid_o, fpu_tag_o, fpu_data_o, req_ready_o);
      end
      if (k == 1) begin
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL hold_busy got %b exp 1", busy_o); end
      end
      $display("hold: cycle %0d tag=%0d valid=%b", k, fpu_tag_o, fpu_valid_o);
    end
    @(negedge clk);
    fpu_ready_i = 1'b1;
    #1;
    checks++;
    if (fpu_tag_o !== 1'b0 || req_ready_o !== 2'b01) begin
      errors++; $display("FAIL hold_release got tag=%0d ready=%b exp 0/01", fpu_tag_o, req_ready_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (fpu_tag_o !== 1'b1 || req_ready_o !== 2'b10 || fpu_data_o !== 256'hE11E) begin
      errors++; $display("FAIL hold_next got tag=%0d ready=%b data=%0h exp 1/10/e11e", fpu_tag_o, req_ready_o, fpu_data_o);
    end
    $display("hold: after release tag=%0d ready=%b", fpu_tag_o, req_ready_o);
    req_valid_i = 2'b00;
  endtask

  task automatic test_rsp_backpressure();
    do_reset();
    fpu_ready_i = 1'b1;
    @(negedge clk);
    req_valid_i = 2'b10;
    #1;
    checks++;
    if (req_ready_o !== 2'b10) begin errors++; $display("FAIL bp_issue got %b exp 10", req_ready_o); end
    @(negedge clk);
    req_valid_i     = 2'b00;
    rsp_ready_i     = 2'b00;
    fpu_rsp_valid_i = 1'b1;
    fpu_rsp_tag_i   = 1'b1;
    fpu_rsp_data_i  = 69'h1F_0000_0001;
    #1;
    checks++;
    if (fpu_rsp_ready_o !== 1'b1) begin errors++; $display("FAIL bp_accept got %b exp 1", fpu_rsp_ready_o); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      fpu_rsp_valid_i = 1'b0;
      #1;
      checks++;
      if (rsp_valid_o !== 2'b10 || fpu_rsp_ready_o !== 1'b0 || rsp_data_o !== 69'h1F_0000_0001 || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL bp_held[%0d] got valid=%b rsp_ready=%b data=%0h busy=%b exp 10/0/1f00000001/1",
                 k, rsp_valid_o, fpu_rsp_ready_o, rsp_data_o, busy_o);
      end
      $display("bp: held cycle %0d rsp_valid=%b", k, rsp_valid_o);
    end
    @(negedge clk);
    rsp_ready_i = 2'b10;
    #1;
    checks++;
    if (rsp_valid_o !== 2'b10 || fpu_rsp_ready_o !== 1'b1) begin
      errors++; $display("FAIL bp_drain got valid=%b rsp_ready=%b exp 10/1", rsp_valid_o, fpu_rsp_ready_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin
      errors++; $display("FAIL bp_empty got valid=%b busy=%b exp 00/0", rsp_valid_o, busy_o);
    end
    $display("bp: after consume busy=%b", busy_o);
  endtask

  task automatic test_flush();
    do_reset();
    fpu_ready_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      req_valid_i = 2'b11;
    end
    @(negedge clk);
    req_valid_i     = 2'b00;
    rsp_ready_i     = 2'b00;
    fpu_rsp_valid_i = 1'b1;
    fpu_rsp_tag_i   = 1'b0;
    fpu_rsp_data_i  = 69'h55;
    @(negedge clk);
    fpu_rsp_tag_i = 1'b1;
    flush_i       = 1'b1;
    req_valid_i   = 2'b11;
    #1;
    checks++;
    if (fpu_flush_o !== 1'b1 || fpu_valid_o !== 1'b0 || req_ready_o !== 2'b00 || fpu_rsp_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_cycle got flush=%b valid=%b ready=%b rsp_ready=%b exp 1/0/00/1",
               fpu_flush_o, fpu_valid_o, req_ready_o, fpu_rsp_ready_o);
    end
    checks++;
    if (rsp_valid_o !== 2'b01 || busy_o !== 1'b1) begin
      errors++; $display("FAIL flush_before got rsp_valid=%b busy=%b exp 01/1", rsp_valid_o, busy_o);
    end
    @(negedge clk);
    flush_i         = 1'b0;
    req_valid_i     = 2'b00;
    fpu_rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (rsp_valid_o !== 2'b00 || busy_o !== 1'b0 || fpu_flush_o !== 1'b0) begin
      errors++; $display("FAIL flush_after got rsp_valid=%b busy=%b flush=%b exp 00/0/0", rsp_valid_o, busy_o, fpu_flush_o);
    end
    $display("flush: after rsp_valid=%b busy=%b", rsp_valid_o, busy_o);
  endtask

  task automatic test_drain();
    do_reset();
    fpu_ready_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      req_valid_i = 2'b01;
    end
    @(negedge clk);
    req_valid_i = 2'b00;
    drain_req_i = 1'b1;
    #1;
    checks++;
    if (drain_done_o !== 1'b0) begin errors++; $display("FAIL drain_early got %b exp 0", drain_done_o); end
    @(negedge clk);
    req_valid_i = 2'b01;
    #1;
    checks++;
    if (req_ready_o !== 2'b00 || fpu_valid_o !== 1'b0) begin
      errors++; $display("FAIL drain_no_issue got ready=%b valid=%b exp 00/0", req_ready_o, fpu_valid_o);
    end
    @(negedge clk);
    fpu_rsp_valid_i = 1'b1;
    fpu_rsp_tag_i   = 1'b0;
    fpu_rsp_data_i  = 69'hAA;
    @(negedge clk);
    fpu_rsp_data_i = 69'hBB;
    #1;
    checks++;
    if (rsp_valid_o !== 2'b01 || rsp_data_o !== 69'hAA || fpu_rsp_ready_o !== 1'b1 || drain_done_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_rsp1 got valid=%b data=%0h rsp_ready=%b done=%b exp 01/aa/1/0",
               rsp_valid_o, rsp_data_o, fpu_rsp_ready_o, drain_done_o);
    end
    @(negedge clk);
    fpu_rsp_valid_i = 1'b0;
    #1;
    checks++;
    if (rsp_valid_o !== 2'b01 || rsp_data_o !== 69'hBB || drain_done_o !== 1'b0 || req_ready_o !== 2'b00) begin
      errors++;
      $display("FAIL drain_rsp2 got valid=%b data=%0h done=%b ready=%b exp 01/bb/0/00",
               rsp_valid_o, rsp_data_o, drain_done_o, req_ready_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (drain_done_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL drain_done got done=%b busy=%b exp 1/0", drain_done_o, busy_o);
    end
    $display("drain: done=%b busy=%b", drain_done_o, busy_o);
    @(negedge clk);
    drain_req_i = 1'b0;
    #1;
    checks++;
    if (drain_done_o !== 1'b1 || req_ready_o !== 2'b00) begin
      errors++; $display("FAIL drain_release got done=%b ready=%b exp 1/00", drain_done_o, req_ready_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (drain_done_o !== 1'b0 || req_ready_o !== 2'b01) begin
      errors++; $display("FAIL drain_resume got done=%b ready=%b exp 0/01", drain_done_o, req_ready_o);
    end
    $display("drain: resume ready=%b", req_ready_o);
    req_valid_i = 2'b00;
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    test_reset();
    test_rr_fairness();
    test_credit_limit();
    test_hold();
    test_rsp_backpressure();
    test_flush();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
